// File: rtl/led_fade_driver.sv
// ----------------------------------------------------------------------------
// led_fade_driver
//   Sits between the 8-bit LED PIO output register and the LED pins. It takes
//   the static on/off pattern and fades each LED between off and full
//   brightness. Each channel keeps its own brightness level, and all channels
//   share one PWM counter.
//
//   Optional build macro: LED_FADE_GAMMA_EN
//     defined   -> the duty latch stores gamma(level) = (level*level) >> PWM_BITS,
//                  with level==MAX mapped to MAX
//     undefined -> the duty latch stores the level unchanged (linear)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pattern_in   target pattern from the PIO (1 = LED on)
//   enable       1 = run; 0 = freeze counters/levels and blank the outputs
//   fade_bypass  1 = levels jump straight to their target
//   led_out      registered PWM drive to the LED pins (1 = lit)
//   busy         registered; 1 while any level differs from its target
//   pwm_sync     one-cycle pulse following the last count of each PWM period
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// led_fade_channel
//   Per-LED level, duty latch and PWM comparator.
// Ports
//   clk, reset_n  clock / async active-low reset
//   enable        run (1) or freeze and blank (0)
//   fade_bypass   load the target directly instead of stepping toward it
//   step_tick     fade step strobe from the shared prescaler
//   period_end    enable && pwm_cnt==MAX; the duty latch updates on it
//   target_on     captured pattern bit for this channel
//   pwm_cnt       shared PWM counter
//   led           registered PWM output
//   mismatch      level != target (combinational; the top ORs and registers it)
// ----------------------------------------------------------------------------
module led_fade_channel #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                fade_bypass,
    input  logic                step_tick,
    input  logic                period_end,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                mismatch
);
    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam logic [PWM_BITS:0]   MAX_EXT = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP    = (PWM_BITS+1)'(FADE_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   sum_ext;
    logic [PWM_BITS:0]   diff_ext;
    logic [PWM_BITS-1:0] duty_src;

    assign target = target_on ? MAX : '0;

    // The extra bit catches overflow on the way up and borrow on the way down,
    // so the level saturates at MAX or 0 and never wraps.
    assign sum_ext  = {1'b0, level_q} + STEP;
    assign diff_ext = {1'b0, level_q} - STEP;

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    // Squaring alone would top out below MAX, so a full-on level is pinned
    // to MAX to keep it solid on.
    assign duty_src = (level_q == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_src = level_q;
`endif

    always_comb begin
        level_d = level_q;
        duty_d  = duty_q;
        led_d   = 1'b0;
        if (enable) begin
            if (fade_bypass) begin
                level_d = target;
            end else if (step_tick) begin
                if (target_on && level_q != MAX) begin
                    // RISING
                    level_d = (sum_ext > MAX_EXT) ? MAX : sum_ext[PWM_BITS-1:0];
                end else if (!target_on && level_q != '0) begin
                    // FALLING
                    level_d = diff_ext[PWM_BITS] ? '0 : diff_ext[PWM_BITS-1:0];
                end
            end
            // The duty value captured here is the level before any step taken
            // in this same cycle. A new level shows up one period later, so a
            // period never changes width partway through.
            if (period_end)
                duty_d = duty_src;
            led_d = (duty_q == MAX) || (pwm_cnt < duty_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            duty_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign led      = led_q;
    assign mismatch = (level_q != target);
endmodule

module led_fade_driver #(
    parameter int NUM_LEDS  = 8,
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 1000,
    parameter int FADE_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                enable,
    input  logic                fade_bypass,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy,
    output logic                pwm_sync
);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                pwm_sync_q, pwm_sync_d;
    logic                busy_q, busy_d;

    logic                step_tick;
    logic                period_end;
    logic [NUM_LEDS-1:0] led_vec;
    logic [NUM_LEDS-1:0] mismatch_vec;

    assign step_tick  = enable && (div_cnt_q == DIV_LAST);
    assign period_end = enable && (pwm_cnt_q == MAX);

    always_comb begin
        pattern_d  = pattern_in;
        pwm_cnt_d  = pwm_cnt_q;
        div_cnt_d  = div_cnt_q;
        pwm_sync_d = period_end;
        busy_d     = |mismatch_vec;
        if (enable) begin
            // MAX + 1 wraps to 0 in PWM_BITS bits.
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q  <= '0;
            pwm_cnt_q  <= '0;
            div_cnt_q  <= '0;
            pwm_sync_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            pwm_cnt_q  <= pwm_cnt_d;
            div_cnt_q  <= div_cnt_d;
            pwm_sync_q <= pwm_sync_d;
            busy_q     <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .enable      (enable),
            .fade_bypass (fade_bypass),
            .step_tick   (step_tick),
            .period_end  (period_end),
            .target_on   (pattern_q[i]),
            .pwm_cnt     (pwm_cnt_q),
            .led         (led_vec[i]),
            .mismatch    (mismatch_vec[i])
        );
    end

    assign led_out  = led_vec;
    assign busy     = busy_q;
    assign pwm_sync = pwm_sync_q;
endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;
    localparam int N    = 8;
    localparam int SD   = 4;
    localparam int FS   = 4;
    localparam int MAXV = 255;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic         enable = 1'b0;
    logic         fade_bypass = 1'b0;
    logic [N-1:0] led_out;
    logic         busy;
    logic         pwm_sync;

    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain integers.
    int m_pat, m_pwm, m_div, m_led, m_busy, m_sync;
    int m_lvl [N];
    int m_duty[N];

    led_fade_driver #(.NUM_LEDS(N), .PWM_BITS(8), .STEP_DIV(SD), .FADE_STEP(FS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pattern_in  (pattern_in),
        .enable      (enable),
        .fade_bypass (fade_bypass),
        .led_out     (led_out),
        .busy        (busy),
        .pwm_sync    (pwm_sync)
    );

    always #5 clk = ~clk;

    function automatic int gamma_of(int l);
`ifdef LED_FADE_GAMMA_EN
        return (l == MAXV) ? MAXV : (l * l) / 256;
`else
        return l;
`endif
    endfunction

    task automatic model_reset();
        m_pat = 0; m_pwm = 0; m_div = 0; m_led = 0; m_busy = 0; m_sync = 0;
        for (int i = 0; i < N; i++) begin m_lvl[i] = 0; m_duty[i] = 0; end
    endtask

    // One clock edge of the reference: all next values come from the old state.
    task automatic model_edge();
        int en, tick, tgt, nled, nbusy;
        int nlvl[N];
        int nduty[N];
        en    = int'(enable);
        tick  = en && (m_div == SD - 1);
        nled  = 0;
        nbusy = 0;
        for (int i = 0; i < N; i++) begin
            tgt = ((m_pat >> i) & 1) ? MAXV : 0;
            if (m_lvl[i] != tgt) nbusy = 1;
            nlvl[i]  = m_lvl[i];
            nduty[i] = m_duty[i];
            if (en && fade_bypass) nlvl[i] = tgt;
            else if (tick && tgt > m_lvl[i]) nlvl[i] = (m_lvl[i] + FS > MAXV) ? MAXV : m_lvl[i] + FS;
            else if (tick && tgt < m_lvl[i]) nlvl[i] = (m_lvl[i] - FS < 0) ? 0 : m_lvl[i] - FS;
            if (en && m_pwm == MAXV) nduty[i] = gamma_of(m_lvl[i]);
            if (en && (m_duty[i] == MAXV || m_pwm < m_duty[i])) nled |= (1 << i);
        end
        m_sync = en && (m_pwm == MAXV);
        m_busy = nbusy;
        m_led  = nled;
        if (en) begin
            m_pwm = (m_pwm + 1) % 256;
            m_div = (m_div + 1) % SD;
        end
        m_pat = int'(pattern_in);
        for (int i = 0; i < N; i++) begin m_lvl[i] = nlvl[i]; m_duty[i] = nduty[i]; end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".led_out"}, int'(led_out), m_led);
        chk({tag, ".busy"}, int'(busy), m_busy);
        chk({tag, ".pwm_sync"}, int'(pwm_sync), m_sync);
    endtask

    // Advance one clock, update the reference, then sample 1 time unit later.
    task automatic step(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (reset_n) model_edge();
            else model_reset();
            #1;
            check_outputs(tag);
        end
    endtask

    initial begin
        int syncs;
        int ones;
        model_reset();
        // Reset state, checked before any clock edge.
        #2;
        check_outputs("reset");
        step("reset_hold", 3);

        // Release with an all-off pattern; no LED lights and nothing is busy.
        reset_n = 1'b1; enable = 1'b1; pattern_in = '0;
        syncs = 0;
        for (int k = 0; k < 1024; k++) begin
            step("idle", 1);
            if (pwm_sync) syncs++;
        end
        chk("idle.sync_count", syncs, 4);
        chk("idle.led_zero", int'(led_out), 0);

        // Fade LED0 all the way up, then confirm that it stays solid on.
        pattern_in = 8'h01;
        step("rise0", 600);
        ones = 0;
        for (int k = 0; k < 256; k++) begin
            step("solid0", 1);
            if (led_out[0]) ones++;
        end
        chk("solid0.count", ones, 256);

        // Reverse partway up (level near 100), fade down to 0 without wrapping.
        pattern_in = 8'h00;
        step("fall0a", 700);
        pattern_in = 8'h01;
        step("rise_mid", 100);
        pattern_in = 8'h00;
        step("fall_mid", 600);

        // Bypass: all levels jump to full.
        fade_bypass = 1'b1; pattern_in = 8'hFF;
        step("bypass_on", 3);
        chk("bypass.busy_settled", int'(busy), 0);
        step("bypass_run", 300);
        chk("bypass.all_lit", int'(led_out), 8'hFF);
        fade_bypass = 1'b0;

        // Freeze in the middle of a fade, then resume.
        pattern_in = 8'h00;
        step("fade_pre_freeze", 60);
        enable = 1'b0;
        step("freeze", 1);
        chk("freeze.led_blank", int'(led_out), 0);
        step("freeze_hold", 500);
        enable = 1'b1;
        step("resume", 700);

        // Reset in the middle of a fade: outputs clear without waiting for a clock.
        pattern_in = 8'h5A;
        step("pre_reset_fade", 150);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        step("reset_mid", 2);
        reset_n = 1'b1;
        step("post_reset", 300);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(63) == 0) pattern_in = N'($urandom);
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(149) == 0) fade_bypass = 1'b1;
            else if ($urandom_range(3) == 0) fade_bypass = 1'b0;
            step("rand", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
